// File: rtl/axis_dwidth_unpack_if.sv
// Stream bundle for axis_dwidth_unpack: wide input beat side (s_*) and word-serial output side (m_*).
interface axis_dwidth_unpack_if #(
  parameter int WORD_WIDTH = 8,
  parameter int BUS_WIDTH  = 64
);
  localparam int WORDS_PER_BEAT = BUS_WIDTH / WORD_WIDTH;

  logic                      s_valid;
  logic                      s_ready;
  logic [BUS_WIDTH-1:0]      s_data;
  logic [WORDS_PER_BEAT-1:0] s_keep;
  logic                      s_last;
  logic                      m_valid;
  logic                      m_ready;
  logic [WORD_WIDTH-1:0]     m_data;
  logic                      m_last;

  // Unpacker side: consumes wide beats, produces single words.
  modport slave (
    input  s_valid, s_data, s_keep, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  // Environment side: produces wide beats, consumes single words.
  modport master (
    output s_valid, s_data, s_keep, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/axis_dwidth_unpack.sv
// AXI-Stream width down-converter: wide keep-qualified beats out as one kept word per cycle, lane 0 first.
// Optional packet word counter enabled by defining AXIS_UNPACK_COUNT_EN.
module axis_dwidth_unpack #(
  parameter int WORD_WIDTH = 8,
  parameter int BUS_WIDTH  = 64
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axis_dwidth_unpack_if.slave     bus,
`ifdef AXIS_UNPACK_COUNT_EN
  output logic [31:0]             pkt_words,
  output logic                    pkt_done,
`endif
  output logic                    err_lost_last
);
  localparam int WORDS_PER_BEAT = BUS_WIDTH / WORD_WIDTH;
  localparam int LANE_W         = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

  logic [BUS_WIDTH-1:0]      data_q;
  logic [WORDS_PER_BEAT-1:0] mask_q;
  logic                      last_q;
  logic                      err_q;

  logic [WORDS_PER_BEAT-1:0] low_bit;
  logic [LANE_W-1:0]         lane;
  logic                      single;
  logic                      m_valid_i;
  logic                      m_last_i;
  logic                      s_ready_i;
  logic                      s_hs;
  logic                      m_hs;

  // Scan from the top so the lowest set lane wins.
  always_comb begin
    lane = '0;
    for (int unsigned i = WORDS_PER_BEAT; i > 0; i--) begin
      if (mask_q[i-1]) lane = LANE_W'(i - 1);
    end
  end

  always_comb begin
    low_bit   = mask_q & (~mask_q + WORDS_PER_BEAT'(1));
    single    = (mask_q != '0) && ((mask_q & (mask_q - WORDS_PER_BEAT'(1))) == '0);
    m_valid_i = |mask_q;
    m_last_i  = last_q && single;
    s_ready_i = (mask_q == '0) || (bus.m_ready && single);
    s_hs      = bus.s_valid && s_ready_i;
    m_hs      = m_valid_i && bus.m_ready;
  end

  assign bus.m_valid   = m_valid_i;
  assign bus.m_last    = m_last_i;
  assign bus.m_data    = data_q[lane*WORD_WIDTH +: WORD_WIDTH];
  assign bus.s_ready   = s_ready_i;
  assign err_lost_last = err_q;

  // A load only happens when empty or the final word leaves, so it overrides the bit-clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
    end else if (s_hs) begin
      data_q <= bus.s_data;
      mask_q <= bus.s_keep;
      last_q <= bus.s_last;
    end else if (m_hs) begin
      mask_q <= mask_q & ~low_bit;
    end
  end

  // A last on an empty beat has no word to ride on; flag it until reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (s_hs && bus.s_last && (bus.s_keep == '0)) begin
      err_q <= 1'b1;
    end
  end

`ifdef AXIS_UNPACK_COUNT_EN
  logic [31:0] cnt_q;

  assign pkt_done  = m_hs && m_last_i;
  assign pkt_words = pkt_done ? (cnt_q + 32'd1) : cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (m_hs) begin
      cnt_q <= pkt_done ? '0 : (cnt_q + 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_axis_dwidth_unpack.sv
// Self-checking bench for axis_dwidth_unpack (16-bit words, 64-bit beats) against a word-queue reference model.
module tb_axis_dwidth_unpack;
  localparam int WW  = 16;
  localparam int BW  = 64;
  localparam int WPB = BW / WW;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } word_t;

  logic aclk = 1'b0;
  logic aresetn;
  logic err_lost_last;
`ifdef AXIS_UNPACK_COUNT_EN
  logic [31:0] pkt_words;
  logic        pkt_done;
`endif

  always #5 aclk = ~aclk;

  axis_dwidth_unpack_if #(.WORD_WIDTH(WW), .BUS_WIDTH(BW)) bus ();

  axis_dwidth_unpack #(.WORD_WIDTH(WW), .BUS_WIDTH(BW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .bus           (bus),
`ifdef AXIS_UNPACK_COUNT_EN
    .pkt_words     (pkt_words),
    .pkt_done      (pkt_done),
`endif
    .err_lost_last (err_lost_last)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  word_t        exp_q[$];
  logic         exp_err = 1'b0;
  int unsigned  pkt_cnt = 0;
  int unsigned  cyc = 0;
  int unsigned  in_cyc = 0;
  logic [WW-1:0] out_data[$];
  logic         out_last[$];
  int unsigned  out_cyc[$];
  int unsigned  done_words[$];
  logic [WW-1:0] obs_data;
  logic         obs_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: every kept lane becomes one word in lane order; last rides on the final kept lane.
  task automatic model_push(input logic [BW-1:0] d, input logic [WPB-1:0] k, input logic l);
    int n;
    n = 0;
    for (int i = 0; i < WPB; i++) begin
      if (k[i]) begin
        exp_q.push_back('{data: d[i*WW +: WW], last: 1'b0});
        n++;
      end
    end
    if (l && n > 0) exp_q[exp_q.size()-1].last = 1'b1;
    if (l && n == 0) exp_err = 1'b1;
  endtask

  task automatic clear_log();
    out_data.delete();
    out_last.delete();
    out_cyc.delete();
    done_words.delete();
  endtask

  task automatic tick(input logic sv, input logic [BW-1:0] d, input logic [WPB-1:0] k,
                      input logic l, input logic mr, output logic hs);
    word_t w;
    logic  exp_sready, exp_mhs, exp_mlast;
    bus.s_valid = sv;
    bus.s_data  = d;
    bus.s_keep  = k;
    bus.s_last  = l;
    bus.m_ready = mr;
    #1;
    obs_data   = bus.m_data;
    obs_valid  = bus.m_valid;
    exp_sready = (exp_q.size() == 0) || (mr && exp_q.size() == 1);
    exp_mlast  = (exp_q.size() != 0) ? exp_q[0].last : 1'b0;
    exp_mhs    = (exp_q.size() != 0) && mr;
    check("s_ready", bus.s_ready, exp_sready);
    check("m_valid", bus.m_valid, exp_q.size() != 0);
    check("m_last", bus.m_last, exp_mlast);
    check("err_lost_last", err_lost_last, exp_err);
    if (exp_q.size() != 0) check("m_data", bus.m_data, exp_q[0].data);
`ifdef AXIS_UNPACK_COUNT_EN
    check("pkt_done", pkt_done, exp_mhs && exp_mlast);
    if (exp_mhs && exp_mlast) begin
      check("pkt_words", pkt_words, pkt_cnt + 1);
      done_words.push_back(pkt_words);
    end
`endif
    if (exp_mhs) begin
      w = exp_q.pop_front();
      out_data.push_back(w.data);
      out_last.push_back(w.last);
      out_cyc.push_back(cyc);
      pkt_cnt = w.last ? 0 : pkt_cnt + 1;
    end
    hs = sv && exp_sready;
    if (hs) begin
      model_push(d, k, l);
      in_cyc = cyc;
    end
    @(posedge aclk);
    @(negedge aclk);
    cyc++;
  endtask

  task automatic idle(input logic mr);
    logic hs;
    tick(1'b0, {$urandom, $urandom}, WPB'($urandom), 1'($urandom), mr, hs);
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input logic [WPB-1:0] k, input logic l, input logic mr);
    logic hs;
    hs = 1'b0;
    for (int i = 0; i < 64 && !hs; i++) tick(1'b1, d, k, l, mr, hs);
    check("send_timeout", hs, 1'b1);
  endtask

  task automatic drain(input logic mr);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) idle(mr);
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    aresetn     = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_last", bus.m_last, 1'b0);
    check("rst_m_data", bus.m_data, '0);
    check("rst_err", err_lost_last, 1'b0);
`ifdef AXIS_UNPACK_COUNT_EN
    check("rst_pkt_words", pkt_words, 0);
    check("rst_pkt_done", pkt_done, 1'b0);
`endif
    exp_q.delete();
    exp_err = 1'b0;
    pkt_cnt = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rst_s_ready", bus.s_ready, 1'b1);
  endtask

  function automatic int count_lasts();
    int n;
    n = 0;
    foreach (out_last[i]) if (out_last[i]) n++;
    return n;
  endfunction

  initial begin
    logic [BW-1:0]  beat;
    logic [WPB-1:0] keep;
    logic           last, hs, pend, mr;
    int unsigned    next_word, cnt, t0;

    do_reset();

    // Two full beats, m_ready=1: words 0..7 back to back.
    clear_log();
    send_beat({16'd3, 16'd2, 16'd1, 16'd0}, 4'hF, 1'b0, 1'b1);
    t0 = in_cyc;
    send_beat({16'd7, 16'd6, 16'd5, 16'd4}, 4'hF, 1'b1, 1'b1);
    drain(1'b1);
    check("full_count", out_data.size(), 8);
    if (out_data.size() == 8) begin
      check("full_latency", out_cyc[0], t0 + 1);
      check("full_no_gap", out_cyc[7] - out_cyc[0], 7);
      check("full_last_pos", out_last[7], 1'b1);
    end
    check("full_last_count", count_lasts(), 1);

    // Sparse keep: lanes 1 and 3 only.
    clear_log();
    send_beat({16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 4'b1010, 1'b1, 1'b1);
    drain(1'b1);
    check("sparse_count", out_data.size(), 2);
    if (out_data.size() == 2) begin
      check("sparse_first", out_data[0], 16'hBBBB);
      check("sparse_second", out_data[1], 16'hDDDD);
      check("sparse_no_gap", out_cyc[1] - out_cyc[0], 1);
      check("sparse_last", out_last[1], 1'b1);
    end

    // Downstream stall: output held stable for 5 cycles.
    send_beat({16'h0040, 16'h0030, 16'h0020, 16'h0010}, 4'hF, 1'b1, 1'b0);
    idle(1'b0);
    t0 = obs_data;
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("stall_data", obs_data, t0);
      check("stall_valid", obs_valid, 1'b1);
    end
    drain(1'b1);

    // Randomized stream of words 0..201 with sparse keeps and random backpressure.
    clear_log();
    next_word = 0;
    pend = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30000; c++) begin
      if (next_word == 202 && !pend && exp_q.size() == 0) break;
      if (!pend && next_word < 202 && $urandom_range(99) < 5) begin
        keep = WPB'($urandom_range(15, 1));
        beat = {$urandom, $urandom};
        cnt  = 0;
        for (int i = 0; i < WPB; i++) begin
          if (keep[i] && next_word + cnt < 202) begin
            beat[i*WW +: WW] = WW'(next_word + cnt);
            cnt++;
          end else begin
            keep[i] = 1'b0;
          end
        end
        last = (next_word + cnt == 202);
        pend = 1'b1;
      end
      mr = ($urandom_range(99) < 20);
      if (pend) tick(1'b1, beat, keep, last, mr, hs);
      else      tick(1'b0, {$urandom, $urandom}, WPB'($urandom), 1'($urandom), mr, hs);
      if (hs) begin
        next_word += cnt;
        pend = 1'b0;
      end
    end
    check("rand_count", out_data.size(), 202);
    check("rand_last_count", count_lasts(), 1);
    if (out_data.size() == 202) check("rand_last_word", out_last[201], 1'b1);
    check("rand_err", err_lost_last, 1'b0);

    // Empty beat carrying last after a full beat: no word gets the last, error flag sticks.
    clear_log();
    send_beat({16'd13, 16'd12, 16'd11, 16'd10}, 4'hF, 1'b0, 1'b1);
    send_beat({$urandom, $urandom}, 4'h0, 1'b1, 1'b1);
    drain(1'b1);
    for (int i = 0; i < 5; i++) idle(1'($urandom));
    check("zk_count", out_data.size(), 4);
    check("zk_last_count", count_lasts(), 0);
    check("zk_err", err_lost_last, 1'b1);

    // Reset with two words still held: dropped at once and never emitted.
    send_beat({16'd23, 16'd22, 16'd21, 16'd20}, 4'hF, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("mid_remaining", exp_q.size(), 2);
    do_reset();
    clear_log();
    for (int i = 0; i < 6; i++) idle(1'b1);
    check("mid_no_residual", out_data.size(), 0);
    check("mid_err_cleared", err_lost_last, 1'b0);

`ifdef AXIS_UNPACK_COUNT_EN
    // Ten-word packet: a single pkt_done pulse reporting 10.
    clear_log();
    send_beat({16'd4, 16'd3, 16'd2, 16'd1}, 4'hF, 1'b0, 1'b1);
    send_beat({16'd8, 16'd7, 16'd6, 16'd5}, 4'hF, 1'b0, 1'b1);
    send_beat({16'hFFFF, 16'hFFFF, 16'd10, 16'd9}, 4'b0011, 1'b1, 1'b1);
    drain(1'b1);
    check("cnt_pulses", done_words.size(), 1);
    if (done_words.size() == 1) check("cnt_value", done_words[0], 10);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
